iq_write: RTL and testbench
===========================

Name: iq_write

Overview:
- Transmit-side counterpart of the IQ read stage.
- Accepts quantized signed I and Q samples (fixed point, QUANTIZE_WIDTH fractional bits) from the demod pipeline.
- Dequantizes each sample with rounding and saturation to 16-bit signed, then packs one I/Q pair per 32-bit word as {Q[15:0], I[15:0]}.
- Pushes each word into a downstream output FIFO under full-flag backpressure.

Parameters:
- DATA_WIDTH, 32: width of the i/q input samples and of the packed output word.
- QUANTIZE_WIDTH, 10: fractional bits removed on dequantize (divide by 2^10, rounded).
- SAMPLE_WIDTH, 16: packed sample width; DATA_WIDTH must equal 2*SAMPLE_WIDTH.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- i_data_in  in  DATA_WIDTH  signed quantized I sample.
- q_data_in  in  DATA_WIDTH  signed quantized Q sample.
- dataAvailible  in  1  upstream I/Q pair valid (upstream not empty).
- in_rd_en  out  1  pop strobe to upstream; a pair is consumed in any cycle where in_rd_en=1 and dataAvailible=1.
- out_full  in  1  downstream FIFO full.
- out_wr_en  out  1  push strobe to downstream FIFO.
- iq_data_out  out  DATA_WIDTH  packed word {Q16, I16}.
- sat_flag  out  1  sticky: some sample has saturated since reset.
- word_count  out  32  number of words pushed since reset; wraps modulo 2^32.

Behaviour:
- Reset (reset=0, asynchronous) clears everything:
  - state=READ, iq_data_out=0, sat_flag=0, word_count=0.
  - Combinational outputs in_rd_en and out_wr_en evaluate to 0 while reset is asserted.
  - Reset mid-operation discards any held word; it is never pushed.
- Dequantize, per sample x:
  - Form r = (x sign-extended to DATA_WIDTH+1 bits) + 2^(QUANTIZE_WIDTH-1), then arithmetic shift right by QUANTIZE_WIDTH. This is round-half-up (toward +inf).
  - If r > 32767, result is 0x7FFF. If r < -32768, result is 0x8000. Otherwise result is r[15:0].
  - Any clamp on I or Q in an accepted pair sets sat_flag on the accept edge.
- Packing: iq_data_out = {Qsat, Isat}; I occupies bits [15:0], Q occupies bits [31:16]. This is bit-exact with the read stage's split.
- FSM has two states: READ and WRITE.
- READ state:
  - in_rd_en=1 and out_wr_en=0.
  - If dataAvailible=1, register the packed word, update sat_flag, and go to WRITE.
  - Otherwise stay in READ.
- WRITE state:
  - out_wr_en = !out_full, with iq_data_out held stable.
  - If out_full=0, the word is pushed this cycle and word_count increments. In the same cycle in_rd_en=1:
    - if dataAvailible=1, the next pair is captured and the FSM stays in WRITE (back-to-back streaming);
    - otherwise the FSM goes to READ.
  - If out_full=1: out_wr_en=0, in_rd_en=0, the FSM stays in WRITE and the word is held indefinitely.
- Latency: a pair accepted on edge N is presented with out_wr_en=1 in cycle N+1 (when not full).
- Throughput: 1 word/cycle sustained with continuous input and no backpressure.
- Invariants:
  - in_rd_en is never 1 while a held word is blocked by out_full.
  - A word is never pushed twice or dropped.
  - out_wr_en is never asserted while out_full=1.

Decomposition:
- Shared package iq_pkg holds:
  - state enum {READ, WRITE}, shared with the read stage;
  - SAMPLE_WIDTH;
  - constants SAMPLE_MAX=16'h7FFF and SAMPLE_MIN=16'h8000;
  - a function for the dequantize/round/saturate step.
- One natural sub-module: iq_dequant_sat. It is purely combinational, one instance each for I and Q, and outputs a 16-bit sample plus a saturation bit.

Test Plan:
- Basic dequantize: I=0x00000400, Q=0xFFFFFC00 -> word 0xFFFF0001, out_wr_en exactly 1 cycle after accept, word_count=1.
- Rounding: I=0x00000200 -> 0x0001; I=0xFFFFFE00 -> 0x0000; I=0x000001FF -> 0x0000; Q=0xFFFFFDFF -> 0xFFFF.
- Saturation: I=0x02000000 -> 0x7FFF, Q=0xFDFFFC00 -> 0x8000 -> word 0x80007FFF, sat_flag=1 and stays 1 across later in-range pairs.
- Round trip: 0x80017FFF through the read stage gives I=0x01FFFC00, Q=0xFE000400; fed to this block -> out word 0x80017FFF, sat_flag=0.
- Backpressure: stream 8 pairs, hold out_full=1 for 5 cycles mid-stream:
  - no in_rd_en while blocked;
  - out_wr_en=0 while full;
  - all 8 words arrive in order with none duplicated;
  - word_count=8;
  - unblocked streaming runs at 1 word/cycle.
- Reset: assert reset=0 asynchronously while in WRITE with out_full=1 -> outputs clear immediately, held word is never pushed, and after release the first new pair is processed normally.

Source files
------------

// File: rtl/iq_pkg.sv
// Shared types and helpers for the IQ read/write stages: FSM states, sample
// limits and the dequantize-with-rounding-and-saturation step.
package iq_pkg;

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } iq_state_t;

    localparam int SAMPLE_WIDTH = 16;
    localparam logic [SAMPLE_WIDTH-1:0] SAMPLE_MAX = 16'h7FFF;
    localparam logic [SAMPLE_WIDTH-1:0] SAMPLE_MIN = 16'h8000;

    typedef struct packed {
        logic [SAMPLE_WIDTH-1:0] sample;
        logic                    sat;
    } deq_t;

    // x is the quantized sample already sign-extended to 64 bits, so the
    // round-half-up addition can never overflow for any input up to 63 bits.
    function automatic deq_t dequant_sat(input logic signed [63:0] x, input int qw);
        logic signed [63:0] r;
        deq_t               res;
        r = (x + (64'sd1 <<< (qw - 1))) >>> qw;
        if (r > 64'sd32767) begin
            res.sample = SAMPLE_MAX;
            res.sat    = 1'b1;
        end else if (r < -64'sd32768) begin
            res.sample = SAMPLE_MIN;
            res.sat    = 1'b1;
        end else begin
            res.sample = r[SAMPLE_WIDTH-1:0];
            res.sat    = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/iq_dequant_sat.sv
// Combinational dequantizer for one sample: divide by 2^QUANTIZE_WIDTH with
// round-half-up, then clamp to a signed 16-bit sample.
module iq_dequant_sat #(
    parameter int DATA_WIDTH     = 32,
    parameter int QUANTIZE_WIDTH = 10
) (
    input  logic [DATA_WIDTH-1:0]            i_sample,
    output logic [iq_pkg::SAMPLE_WIDTH-1:0]  o_sample,
    output logic                             o_sat
);
    import iq_pkg::*;

    logic signed [63:0] w_ext;
    deq_t               w_res;

    assign w_ext    = {{(64-DATA_WIDTH){i_sample[DATA_WIDTH-1]}}, i_sample};
    assign w_res    = dequant_sat(w_ext, QUANTIZE_WIDTH);
    assign o_sample = w_res.sample;
    assign o_sat    = w_res.sat;

endmodule

// File: rtl/iq_write.sv
// IQ write stage: pops quantized I/Q pairs, dequantizes and packs them as
// {Q16, I16}, and pushes one word per cycle into a full-flag output FIFO.
module iq_write #(
    parameter int DATA_WIDTH     = 32,
    parameter int QUANTIZE_WIDTH = 10,
    parameter int SAMPLE_WIDTH   = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] i_data_in,
    input  logic [DATA_WIDTH-1:0] q_data_in,
    input  logic                  dataAvailible,
    output logic                  in_rd_en,
    input  logic                  out_full,
    output logic                  out_wr_en,
    output logic [DATA_WIDTH-1:0] iq_data_out,
    output logic                  sat_flag,
    output logic [31:0]           word_count
);
    import iq_pkg::*;

    iq_state_t             r_state;
    logic [DATA_WIDTH-1:0] r_word;
    logic                  r_sat;
    logic [31:0]           r_count;

    logic [SAMPLE_WIDTH-1:0] w_i_sample;
    logic [SAMPLE_WIDTH-1:0] w_q_sample;
    logic                    w_i_sat;
    logic                    w_q_sat;
    logic [DATA_WIDTH-1:0]   w_packed;
    logic                    w_pair_sat;

    iq_dequant_sat #(
        .DATA_WIDTH     (DATA_WIDTH),
        .QUANTIZE_WIDTH (QUANTIZE_WIDTH)
    ) u_deq_i (
        .i_sample (i_data_in),
        .o_sample (w_i_sample),
        .o_sat    (w_i_sat)
    );

    iq_dequant_sat #(
        .DATA_WIDTH     (DATA_WIDTH),
        .QUANTIZE_WIDTH (QUANTIZE_WIDTH)
    ) u_deq_q (
        .i_sample (q_data_in),
        .o_sample (w_q_sample),
        .o_sat    (w_q_sat)
    );

    assign w_packed   = {w_q_sample, w_i_sample};
    assign w_pair_sat = w_i_sat | w_q_sat;

    // Handshake strobes: a blocked held word stalls both the pop and the push.
    always_comb begin
        in_rd_en  = 1'b0;
        out_wr_en = 1'b0;
        if (!reset) begin
            in_rd_en  = 1'b0;
            out_wr_en = 1'b0;
        end else begin
            case (r_state)
                READ: begin
                    in_rd_en  = 1'b1;
                    out_wr_en = 1'b0;
                end
                WRITE: begin
                    in_rd_en  = !out_full;
                    out_wr_en = !out_full;
                end
                default: begin
                    in_rd_en  = 1'b0;
                    out_wr_en = 1'b0;
                end
            endcase
        end
    end

    // READ/WRITE FSM with the held word, sticky saturation flag and push counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= READ;
            r_word  <= {DATA_WIDTH{1'b0}};
            r_sat   <= 1'b0;
            r_count <= 32'd0;
        end else begin
            case (r_state)
                READ: begin
                    if (dataAvailible) begin
                        r_word  <= w_packed;
                        r_sat   <= r_sat | w_pair_sat;
                        r_state <= WRITE;
                    end else begin
                        r_state <= READ;
                    end
                end
                WRITE: begin
                    if (!out_full) begin
                        r_count <= r_count + 32'd1;
                        if (dataAvailible) begin
                            r_word  <= w_packed;
                            r_sat   <= r_sat | w_pair_sat;
                            r_state <= WRITE;
                        end else begin
                            r_state <= READ;
                        end
                    end else begin
                        r_state <= WRITE;
                    end
                end
                default: begin
                    r_state <= READ;
                end
            endcase
        end
    end

    assign iq_data_out = r_word;
    assign sat_flag    = r_sat;
    assign word_count  = r_count;

endmodule

// File: tb/tb_iq_write.sv
// Directed self-checking bench for iq_write: dequantize/rounding/saturation
// vectors, streaming under backpressure, and asynchronous reset of a held word.
module tb_iq_write;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] i_data_in = 32'h0;
    logic [31:0] q_data_in = 32'h0;
    logic        dataAvailible = 1'b0;
    logic        in_rd_en;
    logic        out_full = 1'b0;
    logic        out_wr_en;
    logic [31:0] iq_data_out;
    logic        sat_flag;
    logic [31:0] word_count;

    int          tests_run    = 0;
    int          tests_failed = 0;
    logic [31:0] push_q[$];

    iq_write #(
        .DATA_WIDTH     (32),
        .QUANTIZE_WIDTH (10),
        .SAMPLE_WIDTH   (16)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .i_data_in     (i_data_in),
        .q_data_in     (q_data_in),
        .dataAvailible (dataAvailible),
        .in_rd_en      (in_rd_en),
        .out_full      (out_full),
        .out_wr_en     (out_wr_en),
        .iq_data_out   (iq_data_out),
        .sat_flag      (sat_flag),
        .word_count    (word_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] i, input logic [31:0] q, input logic av, input logic full);
        @(negedge clock);
        i_data_in     = i;
        q_data_in     = q;
        dataAvailible = av;
        out_full      = full;
        #1;
    endtask

    // Record every push seen by the downstream FIFO and flag any push into a full FIFO.
    always @(posedge clock) begin
        if (out_wr_en === 1'b1) begin
            check("wr_while_full", {31'd0, out_full}, 32'd0);
            push_q.push_back(iq_data_out);
        end
    end

    initial begin
        logic        held;
        int          idx;
        logic        full;
        logic        av;
        logic        exp_rd;
        logic        exp_wr;
        logic [15:0] ks;
        logic [31:0] exp_word;

        // Reset state
        repeat (2) @(negedge clock);
        #1;
        check("rst_rd_en", {31'd0, in_rd_en}, 32'd0);
        check("rst_wr_en", {31'd0, out_wr_en}, 32'd0);
        check("rst_data", iq_data_out, 32'h0);
        check("rst_sat", {31'd0, sat_flag}, 32'd0);
        check("rst_count", word_count, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("idle_rd_en", {31'd0, in_rd_en}, 32'd1);
        check("idle_wr_en", {31'd0, out_wr_en}, 32'd0);

        // Basic dequantize, one-cycle latency
        drive(32'h0000_0400, 32'hFFFF_FC00, 1'b1, 1'b0);
        check("basic_rd_en", {31'd0, in_rd_en}, 32'd1);
        check("basic_wr_pre", {31'd0, out_wr_en}, 32'd0);
        drive(32'h0, 32'h0, 1'b0, 1'b0);
        check("basic_wr", {31'd0, out_wr_en}, 32'd1);
        check("basic_word", iq_data_out, 32'hFFFF_0001);
        drive(32'h0, 32'h0, 1'b0, 1'b0);
        check("basic_wr_post", {31'd0, out_wr_en}, 32'd0);
        check("basic_count", word_count, 32'd1);

        // Rounding, streamed back to back
        drive(32'h0000_0200, 32'hFFFF_FDFF, 1'b1, 1'b0);
        drive(32'hFFFF_FE00, 32'h0000_01FF, 1'b1, 1'b0);
        check("rnd1_wr", {31'd0, out_wr_en}, 32'd1);
        check("rnd1_rd", {31'd0, in_rd_en}, 32'd1);
        check("rnd1_word", iq_data_out, 32'hFFFF_0001);
        drive(32'h0, 32'h0, 1'b0, 1'b0);
        check("rnd2_wr", {31'd0, out_wr_en}, 32'd1);
        check("rnd2_word", iq_data_out, 32'h0000_0000);
        drive(32'h0, 32'h0, 1'b0, 1'b0);
        check("rnd_wr_post", {31'd0, out_wr_en}, 32'd0);
        check("rnd_count", word_count, 32'd3);
        check("rnd_sat", {31'd0, sat_flag}, 32'd0);

        // Saturation, sticky across a later in-range pair
        drive(32'h0200_0000, 32'hFDFF_FC00, 1'b1, 1'b0);
        drive(32'h0000_0400, 32'h0000_0400, 1'b1, 1'b0);
        check("sat_word", iq_data_out, 32'h8000_7FFF);
        check("sat_flag", {31'd0, sat_flag}, 32'd1);
        drive(32'h0, 32'h0, 1'b0, 1'b0);
        check("sat_next_word", iq_data_out, 32'h0001_0001);
        check("sat_sticky", {31'd0, sat_flag}, 32'd1);
        drive(32'h0, 32'h0, 1'b0, 1'b0);
        check("sat_count", word_count, 32'd5);
        check("sat_sticky2", {31'd0, sat_flag}, 32'd1);

        // Asynchronous reset while a word is blocked by out_full
        push_q.delete();
        drive(32'h0000_0400, 32'h0000_0800, 1'b1, 1'b1);
        check("blk_accept_rd", {31'd0, in_rd_en}, 32'd1);
        drive(32'h0, 32'h0, 1'b0, 1'b1);
        check("blk_rd", {31'd0, in_rd_en}, 32'd0);
        check("blk_wr", {31'd0, out_wr_en}, 32'd0);
        check("blk_word", iq_data_out, 32'h0002_0001);
        drive(32'h0, 32'h0, 1'b1, 1'b1);
        check("blk_rd2", {31'd0, in_rd_en}, 32'd0);
        check("blk_word2", iq_data_out, 32'h0002_0001);
        #1;
        reset = 1'b0;
        #1;
        check("arst_rd", {31'd0, in_rd_en}, 32'd0);
        check("arst_wr", {31'd0, out_wr_en}, 32'd0);
        check("arst_word", iq_data_out, 32'h0);
        check("arst_count", word_count, 32'd0);
        check("arst_sat", {31'd0, sat_flag}, 32'd0);
        out_full      = 1'b0;
        dataAvailible = 1'b0;
        @(negedge clock);
        reset = 1'b1;

        // Round trip of a read-stage split after reset
        drive(32'h01FF_FC00, 32'hFE00_0400, 1'b1, 1'b0);
        drive(32'h0, 32'h0, 1'b0, 1'b0);
        check("rt_wr", {31'd0, out_wr_en}, 32'd1);
        check("rt_word", iq_data_out, 32'h8001_7FFF);
        drive(32'h0, 32'h0, 1'b0, 1'b0);
        check("rt_sat", {31'd0, sat_flag}, 32'd0);
        check("rt_count", word_count, 32'd1);
        check("rt_pushes", push_q.size(), 32'd1);
        if (push_q.size() > 0) check("rt_pushed_word", push_q[0], 32'h8001_7FFF);

        // Backpressure: 8 pairs streamed, out_full held for 5 cycles mid-stream
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        push_q.delete();
        held = 1'b0;
        idx  = 0;
        for (int c = 0; c < 20; c++) begin
            full = (c >= 4 && c < 9);
            av   = (idx < 8);
            ks   = 16'(idx + 1);
            drive(32'(idx + 1) << 10, 32'h0 - (32'(idx + 1) << 10), av, full);
            exp_rd = !held || !full;
            exp_wr = held && !full;
            check("bp_rd_en", {31'd0, in_rd_en}, {31'd0, exp_rd});
            check("bp_wr_en", {31'd0, out_wr_en}, {31'd0, exp_wr});
            if (exp_rd && av) begin
                held = 1'b1;
                idx++;
            end else if (held && !full) begin
                held = 1'b0;
            end
        end
        check("bp_count", word_count, 32'd8);
        check("bp_pushes", push_q.size(), 32'd8);
        for (int k = 1; k <= 8; k++) begin
            ks       = 16'(k);
            exp_word = {16'h0000 - ks, ks};
            if (push_q.size() >= k) check("bp_word", push_q[k-1], exp_word);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
